digit_ram_mc: RTL and testbench

- Parametrised multi-lane signed-digit buffer RAM for the online divider datapath; stores digit streams (one 2-bit digit per lane) indexed by iteration.
- Generalises the single-lane 2-bit digit RAM:
  - NUM_CH lanes per word, with per-lane write enables.
  - Registered read with a valid strobe.
  - Selectable read-during-write mode.
  - A sequential clear sweep instead of a combinational whole-array clear, so the array maps to block RAM.
- Sits between the digit-selection stage and the residual-update stage.

---
 rtl/digit_pkg.sv | 8 +
 rtl/digit_ram_mc_if.sv | 27 ++
 rtl/digit_ram_mc_sweeper.sv | 39 +++
 rtl/digit_ram_mc.sv | 62 ++++++
 tb/tb_digit_ram_mc.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/digit_pkg.sv
// digit_pkg: shared digit width, signed-digit encodings and buffer FSM states
package digit_pkg;
  localparam int DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] DIG_ZERO = 2'b00;
  localparam logic [DIGIT_W-1:0] DIG_POS  = 2'b01;
  localparam logic [DIGIT_W-1:0] DIG_NEG  = 2'b11;
  typedef enum logic {CLEAR, READY} state_e;
endpackage

// File: rtl/digit_ram_mc_if.sv
// digit_ram_mc_if: write/read/clear bus of the multi-lane digit buffer
interface digit_ram_mc_if
  import digit_pkg::*;
#(
  parameter int DIGIT_W    = digit_pkg::DIGIT_W,
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 7
);
  logic                      clear_req;
  logic                      we;
  logic [NUM_CH-1:0]         wr_lane_en;
  logic [ADDR_WIDTH-1:0]     write_addr;
  logic [NUM_CH*DIGIT_W-1:0] data;
  logic                      re;
  logic [ADDR_WIDTH-1:0]     read_addr;
  logic [NUM_CH*DIGIT_W-1:0] q;
  logic                      q_valid;
  logic                      busy;
  modport master (
    output clear_req, we, wr_lane_en, write_addr, data, re, read_addr,
    input  q, q_valid, busy
  );
  modport slave (
    input  clear_req, we, wr_lane_en, write_addr, data, re, read_addr,
    output q, q_valid, busy
  );
endinterface

// File: rtl/digit_ram_mc_sweeper.sv
// ram_clear_sweeper: CLEAR/READY FSM stepping a zeroing address across the whole array
module ram_clear_sweeper
  import digit_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  async_clear_n,
  input  logic                  clear_req_i,
  output logic                  busy_o,
  output logic                  sweep_we_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = &cnt_q ? READY : CLEAR;
    end else if (clear_req_i) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy_o       = state_q == CLEAR;
  assign sweep_we_o   = state_q == CLEAR;
  assign sweep_addr_o = cnt_q;
endmodule

// File: rtl/digit_ram_mc.sv
// digit_ram_mc: multi-lane signed-digit buffer RAM with registered read and sweep clear
module digit_ram_mc
  import digit_pkg::*;
#(
  parameter int DIGIT_W    = digit_pkg::DIGIT_W,
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int BYPASS     = 0
) (
  input  logic           clk,
  input  logic           async_clear_n,
  digit_ram_mc_if.slave  bus
);
  localparam int DW    = NUM_CH * DIGIT_W;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DW-1:0]         mem [DEPTH];
  logic                  busy, sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_addr, wa;
  logic                  wr_en;
  logic [NUM_CH-1:0]     lane_we;
  logic [DW-1:0]         wd, lane_mask, rd_old, rd_word, q_q, q_d;
  logic                  q_valid_q;
  ram_clear_sweeper #(.ADDR_WIDTH(ADDR_WIDTH)) u_sweeper (
    .clk          (clk),
    .async_clear_n(async_clear_n),
    .clear_req_i  (bus.clear_req),
    .busy_o       (busy),
    .sweep_we_o   (sweep_we),
    .sweep_addr_o (sweep_addr)
  );
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NUM_CH; k++)
      lane_mask[k*DIGIT_W +: DIGIT_W] = {DIGIT_W{bus.wr_lane_en[k]}};
  end
  // a clear request in READY takes priority over a coincident user write
  assign wr_en   = sweep_we | (bus.we & ~bus.clear_req);
  assign wa      = sweep_we ? sweep_addr : bus.write_addr;
  assign wd      = sweep_we ? '0 : bus.data;
  assign lane_we = sweep_we ? '1 : bus.wr_lane_en;
  always_ff @(posedge clk) begin
    if (wr_en)
      for (int k = 0; k < NUM_CH; k++)
        if (lane_we[k]) mem[wa][k*DIGIT_W +: DIGIT_W] <= wd[k*DIGIT_W +: DIGIT_W];
  end
  assign rd_old  = mem[bus.read_addr];
  assign rd_word = (BYPASS != 0 && wr_en && bus.write_addr == bus.read_addr)
                 ? (rd_old & ~lane_mask) | (bus.data & lane_mask) : rd_old;
  assign q_d     = bus.re ? (busy ? '0 : rd_word) : q_q;
  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      q_valid_q <= bus.re;
    end
  end
  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.busy    = busy;
endmodule

// File: tb/tb_digit_ram_mc.sv
// tb_digit_ram_mc: table vectors, corner sequences and random traffic against a reference model
module tb_digit_ram_mc;
  import digit_pkg::*;
  localparam int DEP = 128;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [3:0] le = '0;
  logic [6:0] wa = '0, ra = '0;
  logic [7:0] d = '0;
  digit_ram_mc_if #(.DIGIT_W(2), .NUM_CH(4), .ADDR_WIDTH(7)) ifa ();
  digit_ram_mc_if #(.DIGIT_W(2), .NUM_CH(4), .ADDR_WIDTH(7)) ifb ();
  assign ifa.clear_req = clr;  assign ifb.clear_req = clr;
  assign ifa.we = we;          assign ifb.we = we;
  assign ifa.wr_lane_en = le;  assign ifb.wr_lane_en = le;
  assign ifa.write_addr = wa;  assign ifb.write_addr = wa;
  assign ifa.data = d;         assign ifb.data = d;
  assign ifa.re = re;          assign ifb.re = re;
  assign ifa.read_addr = ra;   assign ifb.read_addr = ra;
  digit_ram_mc #(.DIGIT_W(2), .NUM_CH(4), .ADDR_WIDTH(7), .BYPASS(0)) dut_a (
    .clk(clk), .async_clear_n(rst_n), .bus(ifa.slave));
  digit_ram_mc #(.DIGIT_W(2), .NUM_CH(4), .ADDR_WIDTH(7), .BYPASS(1)) dut_b (
    .clk(clk), .async_clear_n(rst_n), .bus(ifb.slave));
  always #5 clk = ~clk;

  int         errors = 0, checks = 0;
  logic [7:0] mem_m [DEP];
  int         sweep_left;
  logic [7:0] qm0, qm1;
  logic       qvm;

  typedef struct {
    logic we; logic [3:0] le; logic [6:0] wa; logic [7:0] d;
    logic re; logic [6:0] ra; logic [7:0] q0, q1; logic qv;
  } vec_t;
  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] merge(input logic [7:0] o, input logic [7:0] n, input logic [3:0] en);
    logic [7:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (en[k]) r[2*k +: 2] = n[2*k +: 2];
    return r;
  endfunction

  task automatic model_reset();
    sweep_left = DEP;
    qm0 = '0; qm1 = '0; qvm = 1'b0;
    for (int i = 0; i < DEP; i++) mem_m[i] = '0;
  endtask

  task automatic step();
    logic bm;
    @(posedge clk);
    bm = sweep_left > 0;
    if (re) begin
      qm0 = bm ? 8'h00 : mem_m[ra];
      qm1 = bm ? 8'h00 : ((we && !clr && wa == ra) ? merge(mem_m[ra], d, le) : mem_m[ra]);
    end
    qvm = re;
    if (bm) sweep_left--;
    else if (clr) begin
      sweep_left = DEP;
      for (int i = 0; i < DEP; i++) mem_m[i] = '0;
    end else if (we) mem_m[wa] = merge(mem_m[wa], d, le);
    #1;
    chk("busy_a", ifa.busy, sweep_left > 0);
    chk("busy_b", ifb.busy, sweep_left > 0);
    chk("q_valid_a", ifa.q_valid, qvm);
    chk("q_valid_b", ifb.q_valid, qvm);
    chk("q_a", ifa.q, qm0);
    chk("q_b", ifb.q, qm1);
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; clr = 1'b0; le = '0;
  endtask

  task automatic count_busy(input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ifa.busy && n < 400);
    chk("sweep_cycles", n, exp_n);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEP; a++) begin
      re = 1'b1; ra = 7'(a);
      step();
    end
    idle();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 4'hF, 7'd3,  8'h5A, 1'b0, 7'd0,  8'h00, 8'h00, 1'b0};
    tv[1]  = '{1'b0, 4'h0, 7'd0,  8'h00, 1'b1, 7'd3,  8'h5A, 8'h5A, 1'b1};
    tv[2]  = '{1'b1, 4'h1, 7'd3,  8'hFF, 1'b0, 7'd0,  8'h5A, 8'h5A, 1'b0};
    tv[3]  = '{1'b0, 4'h0, 7'd0,  8'h00, 1'b1, 7'd3,  8'h5B, 8'h5B, 1'b1};
    tv[4]  = '{1'b1, 4'hF, 7'd10, 8'h33, 1'b1, 7'd10, 8'h00, 8'h33, 1'b1};
    tv[5]  = '{1'b0, 4'h0, 7'd0,  8'h00, 1'b1, 7'd10, 8'h33, 8'h33, 1'b1};
    tv[6]  = '{1'b1, 4'h3, 7'd11, 8'h33, 1'b1, 7'd11, 8'h00, 8'h03, 1'b1};
    tv[7]  = '{1'b0, 4'h0, 7'd0,  8'h00, 1'b1, 7'd11, 8'h03, 8'h03, 1'b1};
    tv[8]  = '{1'b1, 4'hF, 7'd20, 8'h77, 1'b1, 7'd3,  8'h5B, 8'h5B, 1'b1};
    tv[9]  = '{1'b0, 4'h0, 7'd0,  8'h00, 1'b0, 7'd0,  8'h5B, 8'h5B, 1'b0};
    tv[10] = '{1'b0, 4'h0, 7'd0,  8'h00, 1'b1, 7'd20, 8'h77, 8'h77, 1'b1};
    model_reset();
    #12;
    chk("reset_q", ifa.q, 8'h00);
    chk("reset_q_valid", ifa.q_valid, 1'b0);
    chk("reset_busy", ifa.busy, 1'b1);
    rst_n = 1'b1;
    count_busy(DEP);
    read_all();
    for (int i = 0; i < 11; i++) begin
      we = tv[i].we; le = tv[i].le; wa = tv[i].wa; d = tv[i].d;
      re = tv[i].re; ra = tv[i].ra; clr = 1'b0;
      step();
      chk($sformatf("vec%0d_q_a", i), ifa.q, tv[i].q0);
      chk($sformatf("vec%0d_q_b", i), ifb.q, tv[i].q1);
      chk($sformatf("vec%0d_qv", i), ifa.q_valid, tv[i].qv);
    end
    idle();
    for (int a = 0; a < DEP; a++) begin
      we = 1'b1; le = 4'hF; wa = 7'(a); d = 8'($urandom_range(1, 255));
      step();
    end
    clr = 1'b1; we = 1'b1; le = 4'hF; wa = 7'd5; d = 8'hC3; re = 1'b0;
    step();
    idle();
    re = 1'b1; ra = 7'd7;
    step();
    chk("read_in_clear_q", ifa.q, 8'h00);
    chk("read_in_clear_qv", ifa.q_valid, 1'b1);
    clr = 1'b1;
    count_busy(DEP - 1);
    idle();
    read_all();
    clr = 1'b1;
    step();
    clr = 1'b0; re = 1'b1; ra = 7'd0;
    repeat (50) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_q", ifa.q, 8'h00);
    chk("midreset_q_valid", ifa.q_valid, 1'b0);
    chk("midreset_busy", ifa.busy, 1'b1);
    idle();
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    count_busy(DEP);
    read_all();
    for (int i = 0; i < 1500; i++) begin
      we = 1'($urandom_range(0, 1)); le = 4'($urandom_range(0, 15));
      wa = 7'($urandom_range(0, 15)); d = 8'($urandom);
      re = 1'($urandom_range(0, 1)); ra = 7'($urandom_range(0, 15));
      clr = 1'($urandom_range(0, 399) == 0);
      step();
    end
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
